// File: rtl/sky130_sram_1rw1r_param.sv
// Parametrised 1RW+1R SRAM model: lane masks, write-first forwarding,
// registered outputs with valid strobes and a hardware clear engine.
module sky130_sram_1rw1r_param #(
    parameter int                    DATA_WIDTH    = 32,
    parameter int                    ADDR_WIDTH    = 8,
    parameter int                    WMASK_WIDTH   = 8,
    parameter bit                    INIT_ON_RESET = 1'b1,
    parameter logic [DATA_WIDTH-1:0] INIT_VALUE    = '0,
    localparam int                   NUM_WMASKS    = DATA_WIDTH / WMASK_WIDTH,
    localparam int                   RAM_DEPTH     = 2 ** ADDR_WIDTH
) (
    input  logic                  clk0,
    input  logic                  rstb0,
    input  logic                  csb0,
    input  logic                  web0,
    input  logic [NUM_WMASKS-1:0] wmask0,
    input  logic [ADDR_WIDTH-1:0] addr0,
    input  logic [DATA_WIDTH-1:0] din0,
    output logic [DATA_WIDTH-1:0] dout0,
    output logic                  dout0_valid,
    input  logic                  csb1,
    input  logic [ADDR_WIDTH-1:0] addr1,
    output logic [DATA_WIDTH-1:0] dout1,
    output logic                  dout1_valid,
    output logic                  collision,
    input  logic                  init_req,
    output logic                  init_busy
);

    typedef enum logic {
        IDLE,
        INIT
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [DATA_WIDTH-1:0] mem [RAM_DEPTH];

    logic                  idle;
    logic                  rd0;
    logic                  wr0;
    logic                  rd1;
    logic                  hit;
    logic [DATA_WIDTH-1:0] bmask;
    logic [DATA_WIDTH-1:0] wr_word;
    logic [DATA_WIDTH-1:0] fwd_word;

    // State register; reset chooses whether the clear engine runs first
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            state <= INIT_ON_RESET ? INIT : IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Clear address counter, restarts at 0 on every entry to INIT
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            cnt <= '0;
        end else if (state == INIT) begin
            cnt <= cnt + 1'b1;
        end else begin
            cnt <= '0;
        end
    end

    // Next-state: leave INIT after the last word has been cleared
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (init_req) state_nxt = INIT;
            INIT: if (cnt == '1) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs
    always_comb begin
        init_busy = (state == INIT);
        idle      = (state == IDLE);
    end

    // Request decode and write-data merge; zero-mask writes are dropped
    always_comb begin
        bmask = '0;
        for (int i = 0; i < NUM_WMASKS; i++) begin
            bmask[i*WMASK_WIDTH +: WMASK_WIDTH] = {WMASK_WIDTH{wmask0[i]}};
        end
        rd0      = idle && !csb0 && web0;
        wr0      = idle && !csb0 && !web0 && (|wmask0);
        rd1      = idle && !csb1;
        hit      = wr0 && (addr0 == addr1);
        wr_word  = (din0 & bmask) | (mem[addr0] & ~bmask);
        fwd_word = (din0 & bmask) | (mem[addr1] & ~bmask);
    end

    // Storage array: clear engine has priority, nothing changes in reset
    always_ff @(posedge clk0) begin
        if (rstb0) begin
            if (state == INIT) begin
                mem[cnt] <= INIT_VALUE;
            end else if (wr0) begin
                mem[addr0] <= wr_word;
            end
        end
    end

    // Registered read ports; data holds when no read is accepted
    always_ff @(posedge clk0 or negedge rstb0) begin
        if (!rstb0) begin
            dout0       <= '0;
            dout0_valid <= 1'b0;
            dout1       <= '0;
            dout1_valid <= 1'b0;
            collision   <= 1'b0;
        end else begin
            dout0_valid <= rd0;
            dout1_valid <= rd1;
            collision   <= rd1 && hit;
            if (rd0) dout0 <= mem[addr0];
            if (rd1) dout1 <= hit ? fwd_word : mem[addr1];
        end
    end

endmodule

// File: tb/tb_sky130_sram_1rw1r_param.sv
// Scoreboard bench for sky130_sram_1rw1r_param: directed vectors,
// expected read data queued at issue, popped by a negedge monitor.
module tb_sky130_sram_1rw1r_param;

    logic        clk0 = 1'b0;
    logic        rstb0, csb0, web0, csb1, init_req;
    logic [3:0]  wmask0;
    logic [7:0]  addr0, addr1;
    logic [31:0] din0, dout0, dout1;
    logic        dout0_valid, dout1_valid, collision, init_busy;

    logic        b_rstb, b_csb0, b_web0, b_csb1, b_init_req;
    logic [3:0]  b_wmask0;
    logic [7:0]  b_addr0, b_addr1;
    logic [31:0] b_din0, b_dout0, b_dout1;
    logic        b_dout0_valid, b_dout1_valid, b_collision, b_init_busy;

    int checks = 0;
    int failures = 0;

    logic [31:0] q0 [$];
    logic [32:0] q1 [$];
    logic [31:0] qb0 [$];
    logic [31:0] qb1 [$];

    always #5 clk0 = ~clk0;

    sky130_sram_1rw1r_param dut (
        .clk0(clk0), .rstb0(rstb0), .csb0(csb0), .web0(web0),
        .wmask0(wmask0), .addr0(addr0), .din0(din0), .dout0(dout0),
        .dout0_valid(dout0_valid), .csb1(csb1), .addr1(addr1),
        .dout1(dout1), .dout1_valid(dout1_valid), .collision(collision),
        .init_req(init_req), .init_busy(init_busy)
    );

    sky130_sram_1rw1r_param #(.INIT_ON_RESET(1'b0)) dut_b (
        .clk0(clk0), .rstb0(b_rstb), .csb0(b_csb0), .web0(b_web0),
        .wmask0(b_wmask0), .addr0(b_addr0), .din0(b_din0), .dout0(b_dout0),
        .dout0_valid(b_dout0_valid), .csb1(b_csb1), .addr1(b_addr1),
        .dout1(b_dout1), .dout1_valid(b_dout1_valid),
        .collision(b_collision), .init_req(b_init_req),
        .init_busy(b_init_busy)
    );

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Monitor: every valid strobe must match the oldest queued expectation
    always @(negedge clk0) begin
        if (rstb0) begin
            if (dout0_valid) begin
                if (q0.size() == 0) chk("p0_unexpected_valid", 1, 0);
                else chk("p0_data", dout0, q0.pop_front());
            end
            if (dout1_valid) begin
                if (q1.size() == 0) chk("p1_unexpected_valid", 1, 0);
                else chk("p1_coll_data", {collision, dout1}, q1.pop_front());
            end else if (collision) begin
                chk("collision_without_valid", 1, 0);
            end
        end
        if (b_rstb) begin
            if (b_dout0_valid) begin
                if (qb0.size() == 0) chk("b_p0_unexpected_valid", 1, 0);
                else chk("b_p0_data", b_dout0, qb0.pop_front());
            end
            if (b_dout1_valid) begin
                if (qb1.size() == 0) chk("b_p1_unexpected_valid", 1, 0);
                else chk("b_p1_data", b_dout1, qb1.pop_front());
            end
        end
    end

    task automatic cyc();
        @(posedge clk0);
        #1;
    endtask

    task automatic idle();
        csb0 = 1'b1; web0 = 1'b1; csb1 = 1'b1; init_req = 1'b0;
        wmask0 = 4'h0; din0 = '0;
    endtask

    task automatic wr(input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] m);
        csb0 = 1'b0; web0 = 1'b0; addr0 = a; din0 = d; wmask0 = m;
        cyc();
        idle();
    endtask

    task automatic rd0(input logic [7:0] a, input logic [31:0] e);
        csb0 = 1'b0; web0 = 1'b1; addr0 = a;
        q0.push_back(e);
        cyc();
        idle();
    endtask

    task automatic rd1(input logic [7:0] a, input logic [31:0] e);
        csb1 = 1'b0; addr1 = a;
        q1.push_back({1'b0, e});
        cyc();
        idle();
    endtask

    // Count cycles with init_busy high, optionally re-pulsing init_req
    task automatic busy_count(input bit extra, output int n);
        n = 0;
        while (init_busy && n < 1000) begin
            n++;
            if (extra && n == 50) init_req = 1'b1;
            cyc();
            init_req = 1'b0;
        end
    endtask

    int n;

    initial begin
        rstb0 = 1'b0; b_rstb = 1'b0;
        idle();
        addr0 = 8'h10; addr1 = 8'h00;
        csb0 = 1'b0; web0 = 1'b1;
        b_csb0 = 1'b1; b_web0 = 1'b1; b_csb1 = 1'b1; b_init_req = 1'b0;
        b_wmask0 = 4'h0; b_addr0 = '0; b_addr1 = '0; b_din0 = '0;

        repeat (3) cyc();
        chk("reset_outputs", {dout0, dout1, dout0_valid, dout1_valid,
                              collision}, '0);
        chk("reset_busy_init_on", init_busy, 1);
        chk("reset_busy_init_off", b_init_busy, 0);

        rstb0 = 1'b1; b_rstb = 1'b1;
        busy_count(1'b0, n);
        chk("power_on_busy_cycles", n, 256);
        q0.push_back(32'h0);
        cyc();
        idle();
        cyc();

        wr(8'h05, 32'hAABBCCDD, 4'hF);
        wr(8'h05, 32'h11223344, 4'h5);
        rd1(8'h05, 32'hAA22CC44);

        csb0 = 1'b0; web0 = 1'b0; addr0 = 8'h07;
        din0 = 32'hDEADBEEF; wmask0 = 4'h3;
        csb1 = 1'b0; addr1 = 8'h07;
        q1.push_back({1'b1, 32'h0000BEEF});
        cyc();
        idle();
        cyc();
        chk("collision_one_cycle", collision, 0);
        rd0(8'h07, 32'h0000BEEF);

        wr(8'h01, 32'h00001111, 4'hF);
        wr(8'h02, 32'h00002222, 4'hF);
        wr(8'h01, 32'hFFFFFFFF, 4'h0);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h01;
        csb1 = 1'b0; addr1 = 8'h02;
        q0.push_back(32'h00001111);
        q1.push_back({1'b0, 32'h00002222});
        cyc();
        chk("both_valid", {dout0_valid, dout1_valid}, 2'b11);
        idle();
        cyc();
        chk("valids_drop", {dout0_valid, dout1_valid}, 2'b00);
        chk("douts_hold", {dout0, dout1}, {32'h00001111, 32'h00002222});

        for (int i = 0; i < 256; i++) begin
            wr(8'(i), {24'hA5A5A5, 8'(i)}, 4'hF);
        end
        rd0(8'h33, 32'hA5A5A533);
        init_req = 1'b1;
        cyc();
        init_req = 1'b0;
        busy_count(1'b1, n);
        chk("scrub_busy_cycles", n, 256);
        rd0(8'h33, 32'h0);
        rd1(8'h00, 32'h0);
        rd0(8'hFF, 32'h0);
        rd1(8'h80, 32'h0);

        wr(8'h30, 32'h5A5A5A5A, 4'hF);
        csb0 = 1'b0; web0 = 1'b1; addr0 = 8'h30;
        csb1 = 1'b0; addr1 = 8'h30;
        q0.push_back(32'h5A5A5A5A);
        q1.push_back({1'b0, 32'h5A5A5A5A});
        cyc();
        idle();
        init_req = 1'b1;
        cyc();
        init_req = 1'b0;
        repeat (100) cyc();
        #2 rstb0 = 1'b0;
        #1;
        chk("midinit_reset_outputs", {dout0, dout1, dout0_valid,
                                      dout1_valid, collision}, '0);
        chk("midinit_reset_busy", init_busy, 1);
        cyc();
        rstb0 = 1'b1;
        busy_count(1'b0, n);
        chk("reinit_busy_cycles", n, 256);
        rd0(8'h30, 32'h0);

        b_csb0 = 1'b0; b_web0 = 1'b0; b_addr0 = 8'h09;
        b_din0 = 32'hCAFEF00D; b_wmask0 = 4'hF;
        cyc();
        b_web0 = 1'b1;
        qb0.push_back(32'hCAFEF00D);
        cyc();
        b_csb0 = 1'b1;
        cyc();
        #2 b_rstb = 1'b0;
        #1;
        chk("b_reset_outputs", {b_dout0, b_dout0_valid, b_init_busy}, '0);
        cyc();
        b_rstb = 1'b1;
        b_csb1 = 1'b0; b_addr1 = 8'h09;
        qb1.push_back(32'hCAFEF00D);
        cyc();
        b_csb1 = 1'b1;

        repeat (3) cyc();
        chk("queues_drained", q0.size() + q1.size() + qb0.size()
                              + qb1.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/sky130_sram_1rw1r_param.md
# sky130_sram_1rw1r_param

Parametrised, synthesizable single-clock 1RW+1R SRAM macro model with per-lane write masks, write-first forwarding to the read port, registered outputs with valid strobes, and a hardware clear engine. It replaces fixed-size 1rw1r models wherever a subsystem needs a configurable width and depth, a defined reset state, or an in-field memory scrub. It sits directly behind cache, scratchpad and FIFO controllers on the same clock domain.

## Interface
- DATA_WIDTH, 32, word width in bits; must be a multiple of WMASK_WIDTH.
- ADDR_WIDTH, 8, address bits; RAM_DEPTH = 2**ADDR_WIDTH words.
- WMASK_WIDTH, 8, bits per write-mask lane; NUM_WMASKS = DATA_WIDTH/WMASK_WIDTH (derived).
- INIT_ON_RESET, 1, when 1 the clear engine runs automatically after reset release.
- INIT_VALUE, 0, DATA_WIDTH-wide word written by the clear engine.
- clk0  in  1  single clock for both ports; all state updates on its rising edge.
- rstb0  in  1  asynchronous, active-low reset.
- csb0  in  1  port 0 active-low chip select.
- web0  in  1  port 0 active-low write enable.
- wmask0  in  NUM_WMASKS  port 0 lane write enables; lane i covers din0[i*WMASK_WIDTH +: WMASK_WIDTH].
- addr0  in  ADDR_WIDTH  port 0 address.
- din0  in  DATA_WIDTH  port 0 write data.
- dout0  out  DATA_WIDTH  port 0 read data.
- dout0_valid  out  1  dout0 carries data from a read accepted on the previous edge.
- csb1  in  1  port 1 (read-only) active-low chip select.
- addr1  in  ADDR_WIDTH  port 1 address.
- dout1  out  DATA_WIDTH  port 1 read data.
- dout1_valid  out  1  dout1 carries data from a read accepted on the previous edge.
- collision  out  1  one-cycle flag aligned with dout1_valid: that read hit the address written on port 0 in the same cycle.
- init_req  in  1  one-cycle pulse that starts the clear engine from IDLE.
- init_busy  out  1  clear engine active; both ports are ignored while high.

## Operation
- FSM states: IDLE, INIT.
  - Reset sends the FSM to INIT if INIT_ON_RESET=1, otherwise to IDLE.
  - IDLE -> INIT on init_req=1.
  - INIT -> IDLE after the write to address RAM_DEPTH-1.
- INIT behaviour:
  - An ADDR_WIDTH-bit counter starts at 0 and writes INIT_VALUE to every lane, one word per cycle, for exactly RAM_DEPTH cycles.
  - init_busy = (state == INIT).
  - init_req while busy is ignored.
- Port 0 accepts a request when csb0=0 and the FSM is in IDLE.
  - web0=0: write. Only the lanes with wmask0[i]=1 are updated. A write with wmask0=0 is a no-op and produces no valid.
  - web0=1: read.
- Port 1 accepts a read when csb1=0 and the FSM is in IDLE.
- Write-first forwarding applies when port 0 writes and port 1 reads the same address in the same cycle.
  - dout1 returns the merged word: new din0 lanes where the mask is set, old contents elsewhere.
  - collision=1 with that dout1_valid.
- dout0/dout1 hold their last value when no read is accepted; they are never driven to X.
- Ignored requests (csb high or FSM busy) cause no memory change and no valid.
- With INIT_ON_RESET=0, memory contents are not touched by reset.

## Timing
- Reset values: dout0=0, dout1=0, dout0_valid=0, dout1_valid=0, collision=0.
- init_busy during reset = INIT_ON_RESET.
- Read latency is 1 cycle. For a read accepted at edge N, dout and valid update at edge N and are stable for the cycle between edges N and N+1. valid drops at edge N+1 unless another read is accepted.
- A write accepted at edge N is visible to any read accepted at edge N+1 or later, on either port. For port 1 it is also visible at edge N itself, via forwarding.
- Clear engine with INIT_ON_RESET=1: busy for RAM_DEPTH cycles after reset deasserts. The first request can be accepted at edge RAM_DEPTH+1 after release.
- init_req pulse at edge N: init_busy goes high after edge N, the word at address 0 is cleared at edge N+1, and init_busy falls after edge N+RAM_DEPTH.
- Asserting rstb0 mid-INIT aborts immediately and clears outputs. The counter restarts at 0 on re-entry to INIT.

## Test plan
- Defaults, INIT_ON_RESET=1: release reset, wait 256 cycles while holding csb0=0, web0=1, addr0=0x10.
  - No dout0_valid while busy.
  - After init_busy falls, read 0x10 -> dout0=0x00000000 with dout0_valid one cycle after the request.
- Masked write: write 0xAABBCCDD with wmask0=0xF to 0x05, then write 0x11223344 with wmask0=0x5 to 0x05, then read on port 1 -> dout1=0xAA22CC44.
- Collision: 0x07 holds 0x0. In the same cycle, port 0 writes 0xDEADBEEF with wmask0=0x3 and port 1 reads 0x07 -> dout1=0x0000BEEF, collision=1 for one cycle.
- Concurrent reads: port 0 reads 0x01 while port 1 reads 0x02 (holding 0x1111, 0x2222) -> both valids high together with the correct data. Next cycle both valids are 0 and the douts hold.
- init_req scrub: fill 0x00-0xFF with nonzero data, pulse init_req, and check init_busy stays high for exactly 256 cycles. Afterwards random reads return INIT_VALUE. A second init_req while busy does not extend init_busy.
- Reset mid-INIT: assert rstb0 at INIT count 100.
  - Outputs clear asynchronously.
  - On release, init_busy stays high for a full 256 cycles.
  - With INIT_ON_RESET=0, previously written data survives reset.
